logic_unit_sched: RTL and testbench

//  Issue scheduler and result buffer for the 32-bit logic functional unit in the Tomasulo core.
//  - Arbitrates round-robin between NUM_RS logic reservation stations.
//  - Executes the selected AND/OR/XOR/NOR op through the bitwise gate datapath.
//  - Holds the tagged result in a one-entry buffer until the CDB grants a broadcast slot.

---
 rtl/lu_pkg.sv | 14 +
 rtl/logic_exec.sv | 33 +++
 rtl/logic_unit_sched.sv | 126 ++++++++++++
 tb/tb_logic_unit_sched.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lu_pkg.sv
// Shared definitions for the 32-bit logic functional unit:
// operation encoding and datapath width.
package lu_pkg;

  localparam int LU_DATA_W = 32;

  typedef enum logic [1:0] {
    LU_AND = 2'b00,
    LU_OR  = 2'b01,
    LU_XOR = 2'b10,
    LU_NOR = 2'b11
  } lu_op_e;

endpackage

// File: rtl/logic_exec.sv
// Bitwise execution datapath of the logic unit: AND, OR and XOR gate
// vectors feed a 2-bit opcode select; NOR is the inverted OR vector.
module logic_exec
  import lu_pkg::*;
(
  input  lu_op_e               op,
  input  logic [LU_DATA_W-1:0] a,
  input  logic [LU_DATA_W-1:0] b,
  output logic [LU_DATA_W-1:0] y
);

  logic [LU_DATA_W-1:0] and_y;
  logic [LU_DATA_W-1:0] or_y;
  logic [LU_DATA_W-1:0] xor_y;

  assign and_y = a & b;
  assign or_y  = a | b;
  assign xor_y = a ^ b;

  // Pick the gate output named by the opcode.
  always_comb begin
    // NOTE: y gets a default before the case so every path assigns it and no latch is inferred.
    y = and_y;
    case (op)
      LU_AND:  y = and_y;
      LU_OR:   y = or_y;
      LU_XOR:  y = xor_y;
      LU_NOR:  y = ~or_y;
      default: y = and_y;
    endcase
  end

endmodule

// File: rtl/logic_unit_sched.sv
// Issue scheduler and one-entry result buffer for the logic functional unit.
// Round-robin arbitration over NUM_RS reservation stations, execution through
// logic_exec, and a tagged result held until the CDB accepts it.
// Optional feature: define LOGIC_UNIT_PERF_EN to add the op_cnt port with
// four wrapping 16-bit per-op grant counters (AND at [15:0] .. NOR at [63:48]).
module logic_unit_sched
  import lu_pkg::*;
#(
  parameter int NUM_RS = 3,
  parameter int TAG_W  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [NUM_RS-1:0]           rs_req,
  input  logic [2*NUM_RS-1:0]         rs_op,
  input  logic [LU_DATA_W*NUM_RS-1:0] rs_a,
  input  logic [LU_DATA_W*NUM_RS-1:0] rs_b,
  input  logic [TAG_W*NUM_RS-1:0]     rs_tag,
  output logic [NUM_RS-1:0]           rs_gnt,
  output logic                        cdb_req,
  input  logic                        cdb_gnt,
  output logic [TAG_W-1:0]            cdb_tag,
  output logic [LU_DATA_W-1:0]        cdb_data
`ifdef LOGIC_UNIT_PERF_EN
  ,
  output logic [63:0]                 op_cnt
`endif
);

  localparam int IDX_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

  logic [IDX_W-1:0]     ptr;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 gnt_any;
  logic                 acc;
  logic                 buf_valid;
  logic [TAG_W-1:0]     buf_tag;
  logic [LU_DATA_W-1:0] buf_data;

  lu_op_e               sel_op;
  logic [LU_DATA_W-1:0] sel_a;
  logic [LU_DATA_W-1:0] sel_b;
  logic [TAG_W-1:0]     sel_tag;
  logic [LU_DATA_W-1:0] exec_y;

  // The buffer can take a new op when empty or when it drains this cycle.
  assign acc = ~buf_valid | cdb_gnt;

  // Round-robin search starting one slot after the last granted station.
  always_comb begin
    int cand;
    cand    = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 1; k <= NUM_RS; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_RS) cand = cand - NUM_RS;
      if (!gnt_any && rs_req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = IDX_W'(cand);
      end
    end
    if (reset || flush || !acc) gnt_any = 1'b0;
  end

  // One-hot grant back to the selected station.
  always_comb begin
    rs_gnt = '0;
    if (gnt_any) rs_gnt[gnt_idx] = 1'b1;
  end

  // Steer the granted station's operands into the shared datapath.
  assign sel_op  = lu_op_e'(rs_op[2*gnt_idx +: 2]);
  assign sel_a   = rs_a[LU_DATA_W*gnt_idx +: LU_DATA_W];
  assign sel_b   = rs_b[LU_DATA_W*gnt_idx +: LU_DATA_W];
  assign sel_tag = rs_tag[TAG_W*gnt_idx +: TAG_W];

  logic_exec u_exec (
    .op (sel_op),
    .a  (sel_a),
    .b  (sel_b),
    .y  (exec_y)
  );

  // Result buffer and pointer: flush squashes, a grant reloads, a CDB grant retires.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: data and tag registers are reset too, because the CDB outputs must read zero after reset.
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= '0;
      ptr       <= IDX_W'(NUM_RS - 1);
    end else if (flush) begin
      buf_valid <= 1'b0;
    end else if (gnt_any) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      buf_valid <= 1'b1;
      buf_tag   <= sel_tag;
      buf_data  <= exec_y;
      ptr       <= gnt_idx;
    end else if (cdb_gnt) begin
      buf_valid <= 1'b0;
    end
  end

  assign cdb_req  = buf_valid;
  assign cdb_tag  = buf_tag;
  assign cdb_data = buf_data;

`ifdef LOGIC_UNIT_PERF_EN
  logic [15:0] cnt [4];

  // Count grants per op type; each counter wraps on overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else if (gnt_any) begin
      cnt[sel_op] <= cnt[sel_op] + 16'd1;
    end
  end

  assign op_cnt = {cnt[3], cnt[2], cnt[1], cnt[0]};
`endif

endmodule

// File: tb/tb_logic_unit_sched.sv
// Self-checking bench for logic_unit_sched: directed scenarios with literal
// expectations, then randomized traffic compared every cycle to a
// behavioural model of the scheduler and result buffer.
module tb_logic_unit_sched;
  import lu_pkg::*;

  localparam int NUM_RS = 3;
  localparam int TAG_W  = 4;
  localparam int DW     = 32;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 flush;
  logic [NUM_RS-1:0]    rs_req;
  logic [2*NUM_RS-1:0]  rs_op;
  logic [DW*NUM_RS-1:0] rs_a;
  logic [DW*NUM_RS-1:0] rs_b;
  logic [TAG_W*NUM_RS-1:0] rs_tag;
  logic [NUM_RS-1:0]    rs_gnt;
  logic                 cdb_req;
  logic                 cdb_gnt;
  logic [TAG_W-1:0]     cdb_tag;
  logic [DW-1:0]        cdb_data;
`ifdef LOGIC_UNIT_PERF_EN
  logic [63:0]          op_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reservation-station contents owned by the bench.
  logic             p_valid [NUM_RS];
  logic [1:0]       p_op    [NUM_RS];
  logic [DW-1:0]    p_a     [NUM_RS];
  logic [DW-1:0]    p_b     [NUM_RS];
  logic [TAG_W-1:0] p_tag   [NUM_RS];

  // Behavioural model state.
  logic             m_valid  = 1'b0;
  logic [TAG_W-1:0] m_tag    = '0;
  logic [DW-1:0]    m_data   = '0;
  int               m_last   = NUM_RS - 1;
  int               edge_gnt = -1;

  logic_unit_sched #(.NUM_RS(NUM_RS), .TAG_W(TAG_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .rs_req   (rs_req),
    .rs_op    (rs_op),
    .rs_a     (rs_a),
    .rs_b     (rs_b),
    .rs_tag   (rs_tag),
    .rs_gnt   (rs_gnt),
    .cdb_req  (cdb_req),
    .cdb_gnt  (cdb_gnt),
    .cdb_tag  (cdb_tag),
    .cdb_data (cdb_data)
`ifdef LOGIC_UNIT_PERF_EN
    ,
    .op_cnt   (op_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] ref_op(input logic [1:0] op, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  // Which station wins this cycle, or -1 if none.
  function automatic int exp_grant();
    if (reset === 1'b1 || flush) return -1;
    if (m_valid && !cdb_gnt) return -1;
    for (int k = 1; k <= NUM_RS; k++) begin
      int i = (m_last + k) % NUM_RS;
      if (p_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [NUM_RS-1:0] exp_mask();
    int g = exp_grant();
    if (g < 0) return '0;
    return NUM_RS'(1) << g;
  endfunction

  // Model update on each edge (reset acts immediately).
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid  <= 1'b0;
      m_tag    <= '0;
      m_data   <= '0;
      m_last   <= NUM_RS - 1;
      edge_gnt <= -1;
    end else begin
      edge_gnt <= exp_grant();
      if (flush) begin
        m_valid <= 1'b0;
      end else if (exp_grant() >= 0) begin
        m_valid <= 1'b1;
        m_data  <= ref_op(p_op[exp_grant()], p_a[exp_grant()], p_b[exp_grant()]);
        m_tag   <= p_tag[exp_grant()];
        m_last  <= exp_grant();
      end else if (cdb_gnt) begin
        m_valid <= 1'b0;
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    check("rs_gnt", rs_gnt, exp_mask());
    check("cdb_req", cdb_req, m_valid);
    if (m_valid) begin
      check("cdb_data", cdb_data, m_data);
      check("cdb_tag", cdb_tag, m_tag);
    end else if (reset === 1'b1) begin
      check("rst_data", cdb_data, 0);
      check("rst_tag", cdb_tag, 0);
    end
  end

  task automatic pack();
    for (int i = 0; i < NUM_RS; i++) begin
      rs_req[i]              = p_valid[i];
      rs_op[2*i +: 2]        = p_op[i];
      rs_a[DW*i +: DW]       = p_a[i];
      rs_b[DW*i +: DW]       = p_b[i];
      rs_tag[TAG_W*i +: TAG_W] = p_tag[i];
    end
  endtask

  task automatic set_rs(input int i, input logic [1:0] op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [TAG_W-1:0] tag);
    p_valid[i] = 1'b1;
    p_op[i]    = op;
    p_a[i]     = a;
    p_b[i]     = b;
    p_tag[i]   = tag;
    pack();
  endtask

  // Advance one edge; the granted station frees its entry.
  task automatic step();
    @(posedge clk);
    #1;
    if (edge_gnt >= 0) p_valid[edge_gnt] = 1'b0;
    pack();
  endtask

  // Keep all three stations requesting with fixed operands; RS2 op/tag selectable.
  task automatic load_trio(input logic [1:0] op2, input logic [TAG_W-1:0] tag2);
    set_rs(0, LU_AND, 32'hFFFF_0000, 32'hFF00_FF00, 4'd1);
    set_rs(1, LU_OR,  32'hFFFF_0000, 32'hFF00_FF00, 4'd2);
    set_rs(2, op2,    32'hFFFF_0000, 32'hFF00_FF00, tag2);
  endtask

  function automatic logic [DW-1:0] rand_word();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return '1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [NUM_RS-1:0] rr_seq [4];
    logic [DW-1:0]     rr_dat [4];
    logic [TAG_W-1:0]  rr_tag [4];
    rr_seq = '{3'b001, 3'b010, 3'b100, 3'b001};
    rr_dat = '{32'hFF00_0000, 32'hFFFF_FF00, 32'h00FF_FF00, 32'hFF00_0000};
    rr_tag = '{4'd1, 4'd2, 4'd3, 4'd1};

    reset   = 1'b1;
    flush   = 1'b0;
    cdb_gnt = 1'b0;
    for (int i = 0; i < NUM_RS; i++) begin
      p_valid[i] = 1'b0; p_op[i] = '0; p_a[i] = '0; p_b[i] = '0; p_tag[i] = '0;
    end
    pack();

    // Reset state, with a requester present that must not be granted.
    set_rs(0, LU_AND, 32'h1234_5678, 32'hFFFF_FFFF, 4'd9);
    #1;
    check("rst_gnt", rs_gnt, 3'b000);
    check("rst_req", cdb_req, 1'b0);
    check("rst_cdb_data", cdb_data, 32'h0);
    check("rst_cdb_tag", cdb_tag, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    p_valid[0] = 1'b0;
    pack();

    // Single OR op on RS1.
    set_rs(1, LU_OR, 32'hF0F0_0000, 32'h0000_0F0F, 4'd5);
    cdb_gnt = 1'b1;
    #1;
    check("t1_gnt", rs_gnt, 3'b010);
    step();
    #1;
    check("t1_req", cdb_req, 1'b1);
    check("t1_data", cdb_data, 32'hF0F0_0F0F);
    check("t1_tag", cdb_tag, 4'd5);
    step();

    // Round-robin from a fresh reset, continuous requests, CDB always granting.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    load_trio(LU_XOR, 4'd3);
    cdb_gnt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_gnt", rs_gnt, rr_seq[k]);
      step();
      load_trio(LU_XOR, 4'd3);
      #1;
      check("rr_req", cdb_req, 1'b1);
      check("rr_data", cdb_data, rr_dat[k]);
      check("rr_tag", cdb_tag, rr_tag[k]);
    end

    // CDB stall for four cycles: no grants, buffered AND result held.
    cdb_gnt = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("stall_gnt", rs_gnt, 3'b000);
      check("stall_req", cdb_req, 1'b1);
      check("stall_data", cdb_data, 32'hFF00_0000);
      check("stall_tag", cdb_tag, 4'd1);
      step();
      load_trio(LU_XOR, 4'd3);
    end
    cdb_gnt = 1'b1;
    #1;
    check("unstall_gnt", rs_gnt, 3'b010);
    step();
    load_trio(LU_NOR, 4'd7);
    #1;
    check("nobubble_req", cdb_req, 1'b1);
    check("nobubble_data", cdb_data, 32'hFFFF_FF00);
    check("nobubble_tag", cdb_tag, 4'd2);
    check("nor_gnt", rs_gnt, 3'b100);
    step();
    load_trio(LU_NOR, 4'd7);
    #1;
    check("nor_data", cdb_data, 32'h0000_00FF);
    check("nor_tag", cdb_tag, 4'd7);

    // Flush beats a simultaneous CDB grant; pointer stays on RS2.
    flush = 1'b1;
    #1;
    check("flush_gnt", rs_gnt, 3'b000);
    step();
    flush = 1'b0;
    load_trio(LU_NOR, 4'd7);
    #1;
    check("flush_req", cdb_req, 1'b0);
    check("flush_ptr_gnt", rs_gnt, 3'b001);
    step();
    load_trio(LU_NOR, 4'd7);
    #1;
    check("post_flush_data", cdb_data, 32'hFF00_0000);

    // Asynchronous reset mid-cycle with a valid buffer; RS0 first afterwards.
    #2;
    reset = 1'b1;
    #1;
    check("areset_req", cdb_req, 1'b0);
    check("areset_data", cdb_data, 32'h0);
    check("areset_gnt", rs_gnt, 3'b000);
    step();
    step();
    reset = 1'b0;
    load_trio(LU_NOR, 4'd7);
    #1;
    check("post_reset_gnt", rs_gnt, 3'b001);

    // Randomized traffic against the model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < NUM_RS; i++) begin
        if (!p_valid[i] && $urandom_range(0, 1) == 1) begin
          p_valid[i] = 1'b1;
          p_op[i]    = 2'($urandom_range(0, 3));
          p_a[i]     = rand_word();
          p_b[i]     = rand_word();
          p_tag[i]   = TAG_W'($urandom_range(0, 15));
        end
      end
      cdb_gnt = ($urandom_range(0, 9) < 7);
      flush   = ($urandom_range(0, 29) == 0);
      reset   = ($urandom_range(0, 299) == 0);
      pack();
      step();
    end
    reset   = 1'b0;
    flush   = 1'b0;
    @(negedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
